// File: rtl/trace_capture_if.sv
// trace_capture_if: 65C02 trace bus plus capture enable.
// The system drives it (master); trace_capture samples it (slave).
interface trace_capture_if;
  logic       enable;
  logic       trace_phi2;
  logic       trace_sync;
  logic       trace_rnw;
  logic [7:0] trace_data;

  modport master (
    output enable,
    output trace_phi2,
    output trace_sync,
    output trace_rnw,
    output trace_data
  );

  modport slave (
    input enable,
    input trace_phi2,
    input trace_sync,
    input trace_rnw,
    input trace_data
  );
endinterface

// File: rtl/trace_capture.sv
// trace_capture: bus cycles -> FIFO -> two-byte 8N1 UART records.
// Macro TRACE_CAPTURE_LOSS_MARK_EN tags the first entry after a drop.
module trace_capture #(
  parameter int CLK_DIV = 434,
  parameter int FIFO_AW = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  trace_capture_if.slave   trace,
  output logic             tx,
  output logic [FIFO_AW:0] fifo_count,
  output logic             overflow,
  output logic             busy
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_MAX =
    BW'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] FULL =
    (FIFO_AW + 1)'(DEPTH);
`ifdef TRACE_CAPTURE_LOSS_MARK_EN
  localparam int EW = 11;
`else
  localparam int EW = 10;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic             r_phi2_q;
  logic [EW-1:0]    r_mem [DEPTH];
  logic [FIFO_AW:0] r_wr;
  logic [FIFO_AW:0] r_rd;
  logic [FIFO_AW:0] r_count;
  logic             r_ovf;
  logic [EW-1:0]    r_hold;
  logic [1:0]       r_state;
  logic [BW-1:0]    r_baud;
  logic [2:0]       r_bit;
  logic             r_sel;

  logic          w_cap;
  logic          w_push;
  logic          w_pop;
  logic          w_bend;
  logic          w_nempty;
  logic          w_lost;
  logic [EW-1:0] w_entry;
  logic [7:0]    w_byte;

  assign w_cap = trace.trace_phi2 & ~r_phi2_q
               & trace.enable;
  assign w_nempty = (r_count != '0);
  assign w_bend = (r_baud == BAUD_MAX);
  assign w_pop = w_nempty
    & ((r_state == S_IDLE)
    | ((r_state == S_STOP) & w_bend & r_sel));
  assign w_push = w_cap & ((r_count < FULL) | w_pop);

`ifdef TRACE_CAPTURE_LOSS_MARK_EN
  logic r_pend;

  assign w_entry = {r_pend, trace.trace_sync,
                    trace.trace_rnw, trace.trace_data};
  assign w_lost = r_hold[10];

  // remember a drop until the next stored entry carries it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_pend <= 1'b0;
    else if (w_cap & ~w_push)
      r_pend <= 1'b1;
    else if (w_push)
      r_pend <= 1'b0;
  end
`else
  assign w_entry = {trace.trace_sync,
                    trace.trace_rnw, trace.trace_data};
  assign w_lost = 1'b0;
`endif

  // strobe history and sticky drop flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phi2_q <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_phi2_q <= trace.trace_phi2;
      if (w_cap & ~w_push)
        r_ovf <= 1'b1;
    end
  end

  // FIFO storage, no reset needed on the array
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr[FIFO_AW-1:0]] <= w_entry;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wr <= r_wr + 1'b1;
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      if (w_push & ~w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop & ~w_push)
        r_count <= r_count - 1'b1;
    end
  end

  // holding register keeps the entry being sent
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_hold <= '0;
    else if (w_pop)
      r_hold <= r_mem[r_rd[FIFO_AW-1:0]];
  end

  // transmitter: start, 8 data, stop; two bytes per entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_sel   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          if (w_nempty) begin
            r_sel   <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bend) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
          end else
            r_baud <= r_baud + 1'b1;
        end
        S_DATA: begin
          if (w_bend) begin
            r_baud <= '0;
            r_bit  <= r_bit + 1'b1;
            if (r_bit == 3'd7)
              r_state <= S_STOP;
          end else
            r_baud <= r_baud + 1'b1;
        end
        S_STOP: begin
          if (w_bend) begin
            r_baud <= '0;
            if (!r_sel) begin
              r_sel   <= 1'b1;
              r_state <= S_START;
            end else if (w_nempty) begin
              r_sel   <= 1'b0;
              r_state <= S_START;
            end else
              r_state <= S_IDLE;
          end else
            r_baud <= r_baud + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // byte select and serial line level
  always_comb begin
    w_byte = r_sel
      ? {4'b0000, r_hold[3:0]}
      : {1'b1, w_lost, r_hold[9:4]};
    tx = 1'b1;
    case (r_state)
      S_START: tx = 1'b0;
      S_DATA:  tx = w_byte[r_bit];
      default: tx = 1'b1;
    endcase
  end

  assign fifo_count = r_count;
  assign overflow   = r_ovf;
  assign busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture: directed tables plus random traffic
// checked against a queue-based cycle model.
module tb_trace_capture;
  localparam int CD = 4;
  localparam int AW = 2;
  localparam int DEPTH = 4;
`ifdef TRACE_CAPTURE_LOSS_MARK_EN
  localparam logic L_EXP = 1'b1;
`else
  localparam logic L_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tx;
  logic [AW:0] fifo_count;
  logic overflow;
  logic busy;

  trace_capture_if trc ();

  trace_capture #(.CLK_DIV(CD), .FIFO_AW(AW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .trace(trc),
    .tx(tx),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .busy(busy)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // reference model: queue of entries, transmitter as a
  // position 0..20*CD-1 inside the entry being sent
  logic [10:0] mq[$];
  logic [10:0] m_hold = '0;
  logic m_busy = 1'b0;
  logic m_ovf = 1'b0;
  logic m_pend = 1'b0;
  logic m_q = 1'b0;
  int m_k = 0;
  logic m_pop;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      mq.delete();
      m_busy = 1'b0;
      m_ovf = 1'b0;
      m_pend = 1'b0;
      m_q = 1'b0;
      m_k = 0;
    end else begin
      m_pop = 1'b0;
      if (m_busy && m_k < 20 * CD - 1)
        m_k++;
      else if (mq.size() > 0)
        m_pop = 1'b1;
      else
        m_busy = 1'b0;
      if (m_pop) begin
        m_hold = mq.pop_front();
        m_busy = 1'b1;
        m_k = 0;
      end
      if (trc.trace_phi2 && !m_q && trc.enable) begin
        if (mq.size() < DEPTH) begin
          mq.push_back({m_pend, trc.trace_sync,
                        trc.trace_rnw, trc.trace_data});
          m_pend = 1'b0;
        end else begin
          m_ovf = 1'b1;
          m_pend = 1'b1;
        end
      end
      m_q = trc.trace_phi2;
    end
  end

  function automatic logic exp_tx();
    int bi;
    int pos;
    logic [7:0] by;
    if (!m_busy) return 1'b1;
    bi = m_k / (10 * CD);
    pos = (m_k % (10 * CD)) / CD;
    if (bi == 0)
      by = {1'b1, L_EXP & m_hold[10], m_hold[9:4]};
    else
      by = {4'b0000, m_hold[3:0]};
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return by[pos-1];
  endfunction

  // every-cycle comparison on the falling edge
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("tx", 32'(tx), 32'(exp_tx()));
      check("fifo_count", 32'(fifo_count), mq.size());
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("busy", 32'(busy), 32'(m_busy));
    end
  end

  // UART receiver: collects bytes as they appear on tx
  logic [7:0] rx_q[$];
  logic [7:0] mon_b;
  initial forever begin
    @(posedge clk);
    #1;
    if (reset_n && tx === 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        repeat (CD) @(posedge clk);
        #1;
        mon_b[i] = tx;
      end
      repeat (CD) @(posedge clk);
      rx_q.push_back(mon_b);
    end
  end

  typedef struct {
    logic       s;
    logic       r;
    logic [7:0] d;
    logic [7:0] b0;
    logic [7:0] b1;
  } vec_t;
  vec_t vt[5];

  task automatic pulse(input logic s, input logic r,
                       input logic [7:0] d);
    trc.trace_sync = s;
    trc.trace_rnw = r;
    trc.trace_data = d;
    trc.trace_phi2 = 1'b1;
    @(posedge clk);
    #1;
    trc.trace_phi2 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int lim, output int n);
    n = 0;
    while (busy && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_idle", 32'(busy), 0);
  endtask

  task automatic chk_rec(input string nm, input int idx,
                         input vec_t v);
    if (rx_q.size() >= idx + 2) begin
      check({nm, "_b0"}, 32'(rx_q[idx]), 32'(v.b0));
      check({nm, "_b1"}, 32'(rx_q[idx+1]), 32'(v.b1));
    end else
      check({nm, "_missing"}, rx_q.size(), idx + 2);
  endtask

  int n;
  int t0;
  logic dense;

  initial begin
    vt[0] = '{1'b1, 1'b1, 8'hA5, 8'hBA, 8'h05};
    vt[1] = '{1'b0, 1'b0, 8'h00, 8'h80, 8'h00};
    vt[2] = '{1'b1, 1'b0, 8'hFF, 8'hAF, 8'h0F};
    vt[3] = '{1'b0, 1'b1, 8'h3C, 8'h93, 8'h0C};
    vt[4] = '{1'b0, 1'b0, 8'h7E, 8'h87, 8'h0E};

    trc.enable = 1'b1;
    trc.trace_phi2 = 1'b0;
    trc.trace_sync = 1'b0;
    trc.trace_rnw = 1'b0;
    trc.trace_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_en = 1'b1;
    check("rst_tx", 32'(tx), 1);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_busy", 32'(busy), 0);

    // single capture with exact timing
    trc.trace_sync = 1'b1;
    trc.trace_rnw = 1'b1;
    trc.trace_data = 8'hA5;
    trc.trace_phi2 = 1'b1;
    @(posedge clk);
    #1;
    check("E_count", 32'(fifo_count), 1);
    check("E_tx", 32'(tx), 1);
    trc.trace_phi2 = 1'b0;
    @(posedge clk);
    #1;
    check("E1_tx", 32'(tx), 0);
    check("E1_busy", 32'(busy), 1);
    check("E1_count", 32'(fifo_count), 0);
    wait_idle(200, n);
    check("entry_clocks", n, 80);
    chk_rec("single", 0, vt[0]);

    // table of records
    for (int i = 1; i < 5; i++) begin
      rx_q.delete();
      pulse(vt[i].s, vt[i].r, vt[i].d);
      wait_idle(200, n);
      check("rec_count", rx_q.size(), 2);
      chk_rec("table", 0, vt[i]);
    end

    // held strobe gives one record
    rx_q.delete();
    trc.trace_sync = vt[3].s;
    trc.trace_rnw = vt[3].r;
    trc.trace_data = vt[3].d;
    trc.trace_phi2 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    trc.trace_phi2 = 1'b0;
    wait_idle(200, n);
    repeat (10) @(posedge clk);
    #1;
    check("held_bytes", rx_q.size(), 2);
    chk_rec("held", 0, vt[3]);

    // disabled capture
    trc.enable = 1'b0;
    repeat (3) pulse(1'b1, 1'b0, 8'h55);
    check("dis_tx", 32'(tx), 1);
    check("dis_count", 32'(fifo_count), 0);
    check("dis_busy", 32'(busy), 0);
    trc.enable = 1'b1;

    // back-to-back drain of three entries
    rx_q.delete();
    pulse(vt[0].s, vt[0].r, vt[0].d);
    t0 = cyc;
    check("b2b_busy", 32'(busy), 1);
    pulse(vt[1].s, vt[1].r, vt[1].d);
    pulse(vt[2].s, vt[2].r, vt[2].d);
    wait_idle(600, n);
    check("b2b_clocks", cyc - t0, 240);
    check("b2b_bytes", rx_q.size(), 6);
    chk_rec("b2b0", 0, vt[0]);
    chk_rec("b2b1", 2, vt[1]);
    chk_rec("b2b2", 4, vt[2]);

    // push coincident with end-of-entry pop at full
    for (int i = 0; i < 5; i++)
      pulse(1'b0, 1'b1, 8'(i));
    repeat (71) @(posedge clk);
    #1;
    check("full_before", 32'(fifo_count), 4);
    trc.trace_phi2 = 1'b1;
    @(posedge clk);
    #1;
    trc.trace_phi2 = 1'b0;
    check("full_pushpop_count", 32'(fifo_count), 4);
    check("full_pushpop_ovf", 32'(overflow), 0);
    wait_idle(800, n);

    // overflow: 6 edges two clocks apart
    for (int i = 0; i < 6; i++)
      pulse(1'b1, 1'b0, 8'(8'h10 + i));
    check("ovf_count", 32'(fifo_count), 4);
    check("ovf_flag", 32'(overflow), 1);
    wait_idle(800, n);
    rx_q.delete();
    pulse(1'b0, 1'b0, 8'h11);
    wait_idle(200, n);
    check("lost_bytes", rx_q.size(), 2);
    if (rx_q.size() >= 1)
      check("lost_mark", 32'(rx_q[0][6]), 32'(L_EXP));
    check("ovf_sticky", 32'(overflow), 1);

    // asynchronous reset in the middle of a data bit
    pulse(1'b0, 1'b1, 8'h5A);
    pulse(1'b1, 1'b1, 8'hC3);
    repeat (8) @(posedge clk);
    #1;
    check("pre_rst_tx", 32'(tx), 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_tx", 32'(tx), 1);
    check("arst_count", 32'(fifo_count), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_ovf", 32'(overflow), 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    rx_q.delete();
    pulse(vt[2].s, vt[2].r, vt[2].d);
    wait_idle(200, n);
    check("post_rst_bytes", rx_q.size(), 2);
    chk_rec("post_rst", 0, vt[2]);

    // random traffic with dense and sparse phases
    for (int c = 0; c < 3000; c++) begin
      dense = ((c / 400) % 2) == 1;
      if (dense ? ($urandom_range(0, 3) != 0)
                : ($urandom_range(0, 40) == 0))
        trc.trace_phi2 = ~trc.trace_phi2;
      trc.enable = ($urandom_range(0, 15) != 0);
      trc.trace_sync = 1'($urandom_range(0, 1));
      trc.trace_rnw = 1'($urandom_range(0, 1));
      trc.trace_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    trc.trace_phi2 = 1'b0;
    wait_idle(2000, n);
    repeat (4) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/trace_capture.md
# trace_capture

Trace capture and UART streamer for the Digiac 65C02 system. It consumes the 11-bit trace bus from the top level: `trace_phi2`, `trace_sync`, `trace_rnw` and `trace_data[7:0]`. Each CPU bus cycle is captured into an on-chip FIFO and drained as two-byte records over a dedicated 8N1 transmit line. The block runs in the `cpu_clk` domain and gives a host-side logic-analyser view of CPU activity.

## Interface
Parameters:
- `CLK_DIV`, default 434: clocks per UART bit (115200 baud at 50 MHz); legal range ≥2.
- `FIFO_AW`, default 9: FIFO address width; depth = 2^FIFO_AW entries.

Ports:
- `clk`  in  1  system clock (`cpu_clk`).
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  capture enable; sampled on the capture edge.
- `trace_phi2`  in  1  trace strobe; a rising edge marks a new bus cycle.
- `trace_sync`  in  1  opcode-fetch flag.
- `trace_rnw`  in  1  1 = read, 0 = write.
- `trace_data`  in  8  bus data.
- `tx`  out  1  serial output, idle high.
- `fifo_count`  out  FIFO_AW+1  number of entries held (excludes the transmit holding register).
- `overflow`  out  1  sticky; 1 once any sample has been dropped.
- `busy`  out  1  1 while the transmitter is not IDLE.

## Operation
**Capture**
- `phi2_q` holds the previous-cycle value of `trace_phi2`.
- A capture edge is any clock edge where `trace_phi2`=1, `phi2_q`=0 and `enable`=1.
- On a capture edge, entry {sync, rnw, data} is pushed at that same clock edge.
- `trace_phi2` held high for several cycles produces exactly one entry.

**FIFO**
- Circular buffer with write pointer, read pointer and count, each FIFO_AW+1 bits. Pointers wrap modulo depth.
- Push is accepted if count < depth, or if a pop occurs on the same edge.
- Otherwise the sample is dropped and `overflow` is set. `overflow` clears only on reset.
- Push and pop on the same edge leave count unchanged.
- Pop is never issued when empty.

**Record format** (2 bytes per entry)
- byte0 = {1, L, sync, rnw, data[7:4]}.
- byte1 = {0000, data[3:0]}.
- Bit 7 set marks byte0, which allows the host to resynchronise.
- L is the lost-sample marker (see Configuration).

**Transmitter FSM**
- States: IDLE, START, DATA, STOP.
- A byte-select flag (0 = byte0, 1 = byte1) chooses the byte being sent.
- IDLE with FIFO non-empty: pop the entry into the holding register, select byte0, go to START.
- START: `tx`=0 for CLK_DIV clocks, then go to DATA.
- DATA: 8 bits, LSB first, CLK_DIV clocks each, tracked by a 3-bit bit counter. Then go to STOP.
- STOP: `tx`=1 for CLK_DIV clocks.
- At the end of STOP after byte0: select byte1, go to START.
- At the end of STOP after byte1: if FIFO non-empty, pop and go to START (back-to-back); otherwise go to IDLE.
- The baud counter counts 0..CLK_DIV-1 and reloads at each bit boundary.

**Reset** (asynchronous, may occur mid-operation)
- FSM goes to IDLE and all pointers and the count clear.
- `tx`=1, `fifo_count`=0, `overflow`=0, `busy`=0, `phi2_q`=0.
- A partially sent byte is abandoned.

## Timing
- Capture edge E: `fifo_count` increments after E.
- If the transmitter is IDLE, the pop happens at E+1. After E+1, `tx`=0 and `busy`=1, and `fifo_count` has dropped back.
- Byte duration is exactly 10×CLK_DIV clocks. Entry duration is exactly 20×CLK_DIV clocks, with no idle gap between byte0 and byte1 or between back-to-back entries.
- `busy` falls on the edge that ends the last stop bit with the FIFO empty.
- Capture edges may arrive as often as every 2 clocks. The FIFO sustains these bursts up to depth+1 entries (depth plus the holding register) before dropping.

## Configuration
`TRACE_CAPTURE_LOSS_MARK_EN`
- Defined:
  - FIFO entries are 11 bits, including a `lost` flag.
  - A pending-loss register is set by a dropped sample.
  - The next accepted push stores `lost`=1 and clears the pending-loss register. If a drop and an accept cannot coincide, the pending flag holds.
  - byte0 bit 6 (L) = the stored `lost` flag.
- Undefined:
  - Entries are 10 bits and L is always 0.
  - The `overflow` output behaves identically in both builds.

## Test plan
Bench parameters: CLK_DIV=4, FIFO_AW=2.
- **Single capture:** `enable`=1, phi2 rising with sync=1, rnw=1, data=0xA5 -> `tx` low from E+1; bytes 0xBA then 0x05, LSB first; 80 clocks total, then `busy`=0.
- **Held strobe / disabled:** phi2 held high 10 cycles -> exactly one record. `enable`=0 with 3 phi2 pulses -> `tx` stays 1 and `fifo_count`=0.
- **Overflow:** 6 capture edges spaced 2 clocks -> entry 1 held for transmit, entries 2–5 stored (`fifo_count`=4), entry 6 dropped, `overflow`=1.
  - With the macro defined: the next accepted sample's byte0 has bit 6 set.
  - With the macro undefined: that bit is clear.
- **Back-to-back drain:** 3 entries queued -> 6 bytes sent in exactly 240 clocks with no idle-high gap longer than one stop bit.
- **Simultaneous push/pop at full:** push coincident with the end-of-entry pop while count=4 -> push accepted, count stays 4, `overflow`=0.
- **Reset mid-byte:** assert `reset_n`=0 during DATA -> `tx`=1, `fifo_count`=0 and `busy`=0 immediately without a clock edge; a new capture after release transmits a correct record.
